controlador_flipping: RTL
=========================

// Module: controlador_flipping
// PURPOSE
// Sequences the bit-reversal flip datapath (mecanismo_flipping_uno) over a frame of
// ROWS x ROW_LEN operand words. It generates the flip select per word from a
// configured mode and applies valid/ready flow control. The output is registered,
// so the block sits between the operand buffer and the PE array feeder.
// PARAMETERS
// N        16  operand word width; flip maps b[i] = a[N-1-i]
// MAX_DIM  64  maximum row length and row count; CW = $clog2(MAX_DIM+1)
// PORTS
// clk        in   1   clock, rising edge
// rst_n      in   1   asynchronous active-low reset
// start      in   1   1-cycle pulse; latches cfg_*; honoured only in IDLE
// abort      in   1   synchronous; return to IDLE, drop in-flight word
// cfg_modo   in   2   00 bypass, 01 always flip, 10 flip odd rows (serpentine), 11 flip odd words
// cfg_len    in   CW  words per row (ROW_LEN)
// cfg_rows   in   CW  rows per frame
// in_valid   in   1   input word valid
// in_data    in   N   input word
// in_ready   out  1   input accepted when in_valid && in_ready
// out_valid  out  1   registered output valid
// out_data   out  N   flipped or passed word
// out_ready  in   1   downstream accepts when out_valid && out_ready
// out_last   out  1   qualifies out_data as last word of a row
// out_flip   out  1   flip select that was applied to out_data
// busy       out  1   high in RUN and DRAIN
// done       out  1   1-cycle pulse at frame completion
// BEHAVIOUR
// - Reset: state IDLE; out_valid, out_data, out_last, out_flip, busy and done all 0;
//   counters and latched cfg cleared.
// - FSM states: IDLE, RUN, DRAIN, DONE.
//   - IDLE & start: latch cfg, clear col/row, go to RUN.
//   - If the latched len==0 or rows==0, go to DONE instead.
//   - RUN: after the last word of the frame is accepted (col==len-1 && row==rows-1),
//     go to DRAIN.
//   - DRAIN: when the output register is empty (or empties this cycle), go to DONE.
//   - DONE: assert done for 1 cycle, then go to IDLE.
// - in_ready = (state==RUN) && (!out_valid || out_ready). It is 0 in IDLE, DRAIN and DONE.
// - Flip select f for the accepted word, by mode: 00 f=0; 01 f=1; 10 f=row[0]; 11 f=col[0].
// - Latency: 1 cycle. The registers out_data=f?rev(in_data):in_data, out_flip=f and
//   out_last=(col==len-1) load on acceptance.
// - out_valid set on acceptance. It clears when out_ready is high and there is no new
//   acceptance in the same cycle. Back-to-back accept+drain gives full throughput.
// - While out_valid && !out_ready, out_data, out_last and out_flip hold stable.
// - Counters: col increments per accepted word. At len-1, col wraps to 0 and row increments.
// - start outside IDLE is ignored; cfg_* is sampled only on the accepted start.
// - abort (any state): next state IDLE, out_valid=0, no done pulse. abort has priority
//   over start in the same cycle.
// - Reset asserted mid-frame: immediate return to the reset values; no partial done.
// - done and busy are never high together; busy=0 in the DONE cycle.
// TESTING
// - Mode 00, len=4, rows=2, in 0x0001..0x0008, out_ready=1 -> 8 words unchanged;
//   out_last on words 4 and 8; done 1 cycle after the DRAIN exit.
// - Mode 10, len=2, rows=2, all inputs 0x0001 -> outputs 0x0001, 0x0001, 0x8000, 0x8000;
//   out_flip 0,0,1,1.
// - Mode 11, len=3, rows=1, in 0x00F0 x3 -> 0x00F0, 0x0F00, 0x00F0.
// - Backpressure: out_ready=0 for 5 cycles mid-frame -> in_ready=0 and out_data stable;
//   no word lost or duplicated.
// - cfg_len=0 with start -> busy never 1; done pulses 2 cycles after start; in_ready stays 0.
// - abort at word 3 of a 8-word frame -> out_valid=0 next cycle, no done; the next start
//   runs a full frame correctly.

Source files
------------

// File: rtl/controlador_flipping.sv
// Purpose : sequences bit-reversal flips over a ROWS x ROW_LEN frame, flip select chosen per word by cfg_modo.
// Latency : 1 cycle from input acceptance to registered output; done pulses 1 cycle after the frame drains.
// Backpres: in_ready drops whenever the output register is full and out_ready is low; held output stays stable.
//
// Ports:
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   start, abort            frame start pulse (IDLE only), synchronous abort (any state, wins over start)
//   cfg_modo/len/rows       flip mode, words per row, rows per frame; latched on an accepted start
//   in_valid/in_ready/in_data     input word handshake
//   out_valid/out_ready/out_data  registered output word handshake
//   out_last, out_flip      last word of a row, flip select applied to out_data
//   busy, done              high in RUN/DRAIN; 1-cycle pulse at frame completion
module controlador_flipping #(
    parameter int N       = 16,
    parameter int MAX_DIM = 64,
    localparam int CW     = $clog2(MAX_DIM + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic [1:0]    cfg_modo,
    input  logic [CW-1:0] cfg_len,
    input  logic [CW-1:0] cfg_rows,
    input  logic          in_valid,
    input  logic [N-1:0]  in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [N-1:0]  out_data,
    input  logic          out_ready,
    output logic          out_last,
    output logic          out_flip,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    modo_q;
    logic [CW-1:0] len_q, rows_q;
    logic [CW-1:0] col_q, row_q;

    logic          out_free;
    logic          accept;
    logic          start_ok;
    logic          last_col;
    logic          last_row;
    logic          flip_sel;
    logic [N-1:0]  data_rev;

    always_comb begin
        out_free = !out_valid || out_ready;
        in_ready = (state_q == S_RUN) && out_free;
        // abort drops the word presented in the same cycle, so it never counts
        accept   = in_valid && in_ready && !abort;
        start_ok = start && (state_q == S_IDLE) && !abort;
        last_col = (col_q == len_q - CW'(1));
        last_row = (row_q == rows_q - CW'(1));
        busy     = (state_q == S_RUN) || (state_q == S_DRAIN);

        case (modo_q)
            2'b00:   flip_sel = 1'b0;
            2'b01:   flip_sel = 1'b1;
            2'b10:   flip_sel = row_q[0];   // serpentine: odd rows reversed
            default: flip_sel = col_q[0];   // odd words reversed
        endcase

        data_rev = '0;
        for (int i = 0; i < N; i++) begin
            data_rev[i] = in_data[N-1-i];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    // empty frame: nothing to move, report completion directly
                    if (cfg_len == '0 || cfg_rows == '0) state_d = S_DONE;
                    else                                 state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (accept && last_col && last_row) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (out_free) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (abort) state_d = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Latched configuration and frame position
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            modo_q <= '0;
            len_q  <= '0;
            rows_q <= '0;
            col_q  <= '0;
            row_q  <= '0;
        end else if (start_ok) begin
            modo_q <= cfg_modo;
            len_q  <= cfg_len;
            rows_q <= cfg_rows;
            col_q  <= '0;
            row_q  <= '0;
        end else if (accept) begin
            if (last_col) begin
                col_q <= '0;
                row_q <= row_q + CW'(1);
            end else begin
                col_q <= col_q + CW'(1);
            end
        end
    end

    // Output register: loads on acceptance, empties on a drain without refill
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_flip  <= 1'b0;
        end else if (abort) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= flip_sel ? data_rev : in_data;
            out_last  <= last_col;
            out_flip  <= flip_sel;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // done is registered from the DONE state, so it never overlaps busy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done <= 1'b0;
        end else begin
            done <= (state_q == S_DONE) && !abort;
        end
    end

endmodule
